// File: rtl/display_pkg.sv
// display_pkg: scan FSM state encoding and default sizes for the result-memory scanout
package display_pkg;
   typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
   localparam int BYTE_W_DEF = 8;
   localparam int DEPTH_DEF  = 320 * 240;
   localparam int ADDR_W_DEF = 17;
endpackage

// File: rtl/display_scanout_bit_packer.sv
// display_scanout_bit_packer: packs returned pixel bits MSB-first into bytes and holds them on a valid/ready output
// Ports: clk, rst (sync, active-high); bit_valid_i/bit_i returned pixel; pad_i shifts in zero
// padding for a partial final byte; out_ready_i sink accept; can_issue_o room for one more read
// next cycle; empty_o no bits collected; out_data_o/out_valid_o packed byte stream.
module display_scanout_bit_packer
   import display_pkg::*;
#(
   parameter int BYTE_W = BYTE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_valid_i,
   input  logic              bit_i,
   input  logic              pad_i,
   input  logic              out_ready_i,
   output logic              can_issue_o,
   output logic              empty_o,
   output logic [BYTE_W-1:0] out_data_o,
   output logic              out_valid_o
);
   localparam int CW = $clog2(BYTE_W + 1);
   logic [BYTE_W-1:0] sr_q, sr_d, out_q, out_d;
   logic [CW-1:0]     coll_q, coll_d;
   logic              valid_q, valid_d, full, shift, load;
   // A byte completes either when the bit finishing it arrives or, after a stall, when the
   // full shift register can finally move out; the count after this cycle gates new reads
   // so an issued read always finds room when its data returns.
   always_comb begin
      full    = coll_q == CW'(BYTE_W);
      shift   = bit_valid_i || (pad_i && coll_q != '0 && !full);
      load    = (full || (shift && coll_q == CW'(BYTE_W - 1))) && (!valid_q || out_ready_i);
      sr_d    = shift ? {sr_q[BYTE_W-2:0], bit_i & bit_valid_i} : sr_q;
      out_d   = load ? (full ? sr_q : sr_d) : out_q;
      coll_d  = load ? CW'(full && shift) : coll_q + CW'(shift);
      valid_d = load || (valid_q && !out_ready_i);
   end
   assign can_issue_o = coll_d < CW'(BYTE_W);
   assign empty_o     = coll_q == '0;
   assign out_data_o  = out_q;
   assign out_valid_o = valid_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q    <= '0;
         out_q   <= '0;
         coll_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         out_q   <= out_d;
         coll_q  <= coll_d;
         valid_q <= valid_d;
      end
   end
endmodule

// File: rtl/display_scanout.sv
// display_scanout: sweeps the 1-bit result memory and streams the pixels as MSB-first packed bytes
// Ports: clk, rst (sync, active-high); start begins a scan from IDLE or DONE; ena_display,
// read_display, addr_display, dout_display result-memory read port (1-cycle latency);
// out_data/out_valid/out_ready byte stream; busy during SCAN/FLUSH; finished in DONE.
module display_scanout
   import display_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int BYTE_W = BYTE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              ena_display,
   output logic              read_display,
   output logic [ADDR_W-1:0] addr_display,
   input  logic              dout_display,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              finished
);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inflight_q, issue, can_issue, empty, last;
   assign last = addr_q == ADDR_W'(DEPTH - 1);
   // The address counter parks on the last address so it never needs a wider counter.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      issue   = state_q == SCAN && can_issue;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = SCAN;
            addr_d  = '0;
         end
         SCAN: if (issue) begin
            state_d = last ? FLUSH : SCAN;
            addr_d  = last ? addr_q : addr_q + ADDR_W'(1'b1);
         end
         FLUSH: state_d = (!inflight_q && empty && !out_valid) ? DONE : FLUSH;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         inflight_q <= issue;
      end
   end
   assign ena_display  = state_q == SCAN || inflight_q;
   assign read_display = issue;
   assign addr_display = addr_q;
   assign busy         = state_q == SCAN || state_q == FLUSH;
   assign finished     = state_q == DONE;
   display_scanout_bit_packer #(.BYTE_W(BYTE_W)) u_packer (
      .clk         (clk),
      .rst         (rst),
      .bit_valid_i (inflight_q),
      .bit_i       (dout_display),
      .pad_i       (state_q == FLUSH && !inflight_q),
      .out_ready_i (out_ready),
      .can_issue_o (can_issue),
      .empty_o     (empty),
      .out_data_o  (out_data),
      .out_valid_o (out_valid)
   );
endmodule

// File: tb/tb_display_scanout.sv
// tb_display_scanout: scoreboard bench for display_scanout with a 20-pixel memory (final byte padded)
module tb_display_scanout;
   localparam int AW = 5;
   localparam int DP = 20;
   localparam int BW = 8;
   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, dout_display = 1'b0, out_ready = 1'b1;
   logic          ena_display, read_display, out_valid, busy, finished;
   logic [AW-1:0] addr_display;
   logic [BW-1:0] out_data;
   int            tests = 0, fails = 0;
   logic [DP-1:0] pat = '0;
   logic [BW-1:0] exp_q[$];
   int            rd_cnt = 0, byte_cnt = 0, exp_addr = 0;
   int            rmode = 0, hold = 0;
   bit            hold_done = 1'b0, stall_prev = 1'b0;
   logic [BW-1:0] data_prev = '0;

   always #5 clk = ~clk;

   display_scanout #(.ADDR_W(AW), .DEPTH(DP), .BYTE_W(BW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .ena_display  (ena_display),
      .read_display (read_display),
      .addr_display (addr_display),
      .dout_display (dout_display),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .finished     (finished)
   );

   // result memory: pixel i is pat[DP-1-i], data one cycle after the read strobe
   always @(posedge clk) if (read_display) dout_display <= pat[DP - 1 - int'(addr_display)];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: read-address order, output bytes against the scoreboard, stall stability
   always @(negedge clk) begin
      if (!rst) begin
         if (stall_prev) check("stall_hold", {23'b0, out_valid, out_data}, {23'b0, 1'b1, data_prev});
         if (read_display) begin
            check("rd_addr", 32'(addr_display), 32'(exp_addr));
            exp_addr++;
            rd_cnt++;
         end
         if (out_valid && out_ready) begin
            byte_cnt++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_byte: got %0h expected none", out_data);
            end else check("byte", 32'(out_data), 32'(exp_q.pop_front()));
         end
      end
      stall_prev = out_valid && !out_ready && !rst;
      data_prev  = out_data;
   end

   // sink: 0 always ready, 1 toggling, 2 stalled 20 cycles after the first out_valid
   initial forever begin
      @(posedge clk);
      #1;
      if (rmode == 1) out_ready = ~out_ready;
      else if (rmode == 2 && hold > 0) begin
         if (hold <= 10) check("read_stall", 32'(read_display), 32'd0);
         hold--;
         out_ready = 1'b0;
      end else if (rmode == 2 && !hold_done && out_valid) begin
         hold      = 19;
         hold_done = 1'b1;
         out_ready = 1'b0;
      end else out_ready = 1'b1;
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_scan(input logic [DP-1:0] p, input logic [BW-1:0] b0, b1, b2,
                           input int mode, input bit lat_chk, input bit restart);
      int n;
      pat       = p;
      rmode     = mode;
      hold      = 0;
      hold_done = 1'b0;
      exp_addr  = 0;
      rd_cnt    = 0;
      byte_cnt  = 0;
      exp_q.push_back(b0);
      exp_q.push_back(b1);
      exp_q.push_back(b2);
      pulse_start();
      check("fin_drop", 32'(finished), 32'd0);
      check("busy_on", 32'(busy), 32'd1);
      if (lat_chk) begin
         n = 0;
         while (!out_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
         end
         check("latency", 32'(n), 32'(BW + 1));
      end
      if (restart) begin
         repeat (3) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         check("busy_ignore", 32'(busy), 32'd1);
      end
      n = 0;
      while (!finished && n < 500) begin
         @(posedge clk);
         #1 n++;
      end
      check("finished", 32'(finished), 32'd1);
      check("busy_off", 32'(busy), 32'd0);
      check("bytes", 32'(byte_cnt), 32'd3);
      check("reads", 32'(rd_cnt), 32'(DP));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_state", 32'({ena_display, read_display, out_valid, busy, finished, addr_display, out_data}), 32'd0);
      run_scan(20'b1010_1010_1100_0011_1011, 8'hAA, 8'hC3, 8'hB0, 0, 1'b1, 1'b0);
      run_scan(20'hFFFFF, 8'hFF, 8'hFF, 8'hF0, 0, 1'b0, 1'b0);
      run_scan(20'b0110_1001_0001_1110_0111, 8'h69, 8'h1E, 8'h70, 2, 1'b0, 1'b0);
      run_scan(20'b1100_1010_0101_1111_1001, 8'hCA, 8'h5F, 8'h90, 1, 1'b0, 1'b0);
      // reset while the read of address 5 is in flight
      rmode    = 0;
      exp_addr = 0;
      pat      = 20'hFFFFF;
      pulse_start();
      n = 0;
      while (!(read_display && addr_display == AW'(5)) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reach_addr5", 32'(addr_display), 32'd5);
      @(posedge clk);
      #1 rst = 1'b1;
      check("ena_inflight", 32'(ena_display), 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      check("midscan_reset", 32'({ena_display, read_display, out_valid, busy, finished, addr_display, out_data}), 32'd0);
      repeat (3) @(posedge clk);
      check("reset_idle", 32'({ena_display, read_display, out_valid, busy, finished}), 32'd0);
      run_scan(20'b1100_1010_0101_1111_1001, 8'hCA, 8'h5F, 8'h90, 0, 1'b1, 1'b0);
      run_scan(20'b0110_1001_0001_1110_0111, 8'h69, 8'h1E, 8'h70, 0, 1'b0, 1'b1);
      run_scan(20'b0110_1001_0001_1110_0111, 8'h69, 8'h1E, 8'h70, 0, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
